axil_uart_tx_fifo: RTL

AXI4-Lite UART slave device. It buffers written bytes in a parametrised TX FIFO and serialises them 8N1 on a tx line at a programmable baud divisor. It also exposes status and divisor registers for read.
Read and write responses carry a pseudo-random latency so the bus master is stressed. It sits on the CPU's AXI4-Lite crossbar as the console device.

---
 rtl/axil_uart_tx_fifo.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_uart_tx_fifo.sv
// axil_uart_tx_fifo
//   AXI4-Lite console UART. Bytes written to TXDATA are queued in a TX FIFO
//   and sent 8N1 on tx with a bit time of DIV+1 clk cycles. Read and write
//   responses are issued after a delay d taken from an LFSR so the master
//   sees varying latency.
//
//   Build option: define UART_RAND_DELAY_EN to enable the LFSR-driven
//   response delay; otherwise d = 0 and the LFSR is not built.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   ar*/r*               AXI4-Lite read address / read data channels
//   aw*/w*/b*            AXI4-Lite write address / data / response channels
//   tx                   serial output, idles high
//
// Register map (addr[3:2]): 0 TXDATA (wo), 1 STATUS (ro), 2 DIV (rw), 3 DECERR
module axil_uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DIV_RESET  = 15,
    parameter int unsigned DELAY_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} s_state_t;

    // ---------------- response delay source ----------------
    logic [DELAY_W-1:0] d_new;
`ifdef UART_RAND_DELAY_EN
    logic [7:0] lfsr;
    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 8'hFF;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign d_new = lfsr[DELAY_W-1:0];
`else
    assign d_new = '0;
`endif

    // ---------------- TX FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);

    logic [DIV_W-1:0] div;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic [1:0]       w_addr;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= w_data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- serialiser ----------------
    s_state_t         s_state, s_next;
    logic [DIV_W-1:0] bcnt, div_l;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             bit_end;

    assign bit_end = (bcnt == div_l);

    always_comb begin
        s_next = s_state;
        pop    = 1'b0;
        tx     = 1'b1;
        case (s_state)
            S_IDLE: if (!empty) begin pop = 1'b1; s_next = S_START; end
            S_START: begin
                tx = 1'b0;
                if (bit_end) s_next = S_DATA;
            end
            S_DATA: begin
                tx = shreg[0];
                if (bit_end && bit_idx == 3'd7) s_next = S_STOP;
            end
            S_STOP: if (bit_end) begin
                if (!empty) begin pop = 1'b1; s_next = S_START; end
                else        s_next = S_IDLE;
            end
            default: s_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_state <= S_IDLE;
        else     s_state <= s_next;
    end

    // DIV is sampled only when a byte is popped, so a frame in flight keeps its rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt    <= '0;
            div_l   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (pop) begin
            shreg   <= mem[rptr];
            div_l   <= div;
            bcnt    <= '0;
            bit_idx <= '0;
        end else if (s_state != S_IDLE) begin
            if (bit_end) begin
                bcnt <= '0;
                if (s_state == S_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bcnt <= bcnt + DIV_W'(1);
            end
        end
    end

    // ---------------- register read view ----------------
    logic [31:0] status;
    logic [7:0]  count8;
    assign count8 = 8'(count);
    assign status = {16'h0, count8, 5'b0, (s_state != S_IDLE), empty, full};

    // ---------------- read channel ----------------
    r_state_t           r_state, r_next;
    logic [1:0]         r_addr;
    logic [DELAY_W-1:0] r_cnt;
    logic [31:0]        rd_val;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_RESP);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_next = R_WAIT;
            R_WAIT:  if (r_cnt == '0) r_next = R_RESP;
            R_RESP:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (r_addr)
            2'd1:    rd_val = status;
            2'd2:    rd_val = 32'(div);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && arvalid) begin
                r_addr <= araddr[3:2];
                r_cnt  <= d_new;
            end else if (r_state == R_WAIT) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - DELAY_W'(1);
                end else begin
                    rdata <= rd_val;
                    rresp <= (r_addr == 2'd3) ? 2'b11 : 2'b00;
                end
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t           w_state, w_next;
    logic [DELAY_W-1:0] w_cnt;
    logic               aw_got, w_got, aw_hs, w_hs, aw_have, w_have;
    logic               apply, push_req;

    assign awready  = (w_state == W_IDLE) && !aw_got;
    assign wready   = (w_state == W_IDLE) && !w_got;
    assign bvalid   = (w_state == W_RESP);
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign aw_have  = aw_got || aw_hs;
    assign w_have   = w_got || w_hs;
    assign apply    = (w_state == W_WAIT) && (w_cnt == '0);
    assign push_req = apply && (w_addr == 2'd0) && w_strb[0];
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push     = push_req && (!full || pop);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_have && w_have) w_next = W_WAIT;
            W_WAIT:  if (w_cnt == '0) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_addr  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            w_cnt   <= '0;
            bresp   <= '0;
            div     <= DIV_W'(DIV_RESET);
        end else begin
            w_state <= w_next;
            if (aw_hs) w_addr <= awaddr[3:2];
            if (w_hs) begin
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (w_state == W_IDLE && !(aw_have && w_have)) begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end else begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (w_state == W_IDLE && aw_have && w_have)
                w_cnt <= d_new;
            else if (w_state == W_WAIT && w_cnt != '0)
                w_cnt <= w_cnt - DELAY_W'(1);
            if (apply) begin
                if (push_req && !push)   bresp <= 2'b10;
                else if (w_addr == 2'd3) bresp <= 2'b11;
                else                     bresp <= 2'b00;
                if (w_addr == 2'd2) begin
                    for (int unsigned i = 0; i < DIV_W; i++)
                        if (w_strb[i/8]) div[i] <= w_data[i];
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{araddr[31:4], araddr[1:0], awaddr[31:4], awaddr[1:0],
                           w_data, w_strb};
endmodule
